screen_reader: RTL and testbench
================================

Name: screen_reader

Overview:
- Downstream consumer of the CHIP-8 framebuffer that the sprite-drawing GPU writes.
- Framebuffer layout: 64 x 32 monochrome, 8 bytes per row, MSB = leftmost pixel, 256 bytes from SCREEN_START.
- On a start pulse, reads every framebuffer byte in address order over the shared byte-wide memory port.
- Streams each byte, tagged with row/column, to a display driver through a valid/ready handshake.

Parameters:
- SCREEN_START, 'h100, byte address of framebuffer row 0, column 0.
- SCREEN_BYTES, 256, bytes per frame; must be a power of two between 8 and 256.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin one frame scan; sampled only in IDLE.
- ready  out  1  high exactly when state is IDLE (combinational from state).
- frame_done  out  1  one-cycle pulse after the last byte is accepted.
- mem_grant  in  1  arbiter permits a read this cycle.
- mem_read  out  1  one-cycle read strobe.
- mem_addr  out  16  read address; 0 when mem_read is low.
- mem_read_byte  in  8  read data, valid in the cycle after the cycle mem_read is high.
- out_valid  out  1  out_byte/out_row/out_col hold valid data.
- out_ready  in  1  sink accepts the current byte.
- out_byte  out  8  framebuffer byte.
- out_row  out  5  pixel row 0..31 (index / 8).
- out_col  out  3  byte column 0..7 (index % 8).
- out_first  out  1  high with index 0.
- out_last  out  1  high with index SCREEN_BYTES-1.

Behaviour:
- Reset, asynchronous on rst_n low: state IDLE; index 0; every output 0 except ready=1. Reset mid-frame abandons the frame with no frame_done.
- mem_read, mem_addr and frame_done are registered and default to 0 every cycle unless set.
- IDLE, start=1: index<=0, go to ISSUE. start while not IDLE is ignored and not queued.
- ISSUE, mem_grant=1: mem_read<=1, mem_addr<=SCREEN_START+index (16-bit, wraps mod 2^16), go to CAPTURE.
- ISSUE, mem_grant=0: stay; mem_read stays 0.
- CAPTURE: wait while mem_read=1. When mem_read=0: out_byte<=mem_read_byte, out_row/out_col/out_first/out_last from index, out_valid<=1, go to OUTPUT.
- OUTPUT: all out_* held stable while out_valid && !out_ready.
- OUTPUT, out_ready=1: out_valid<=0.
  - Index != SCREEN_BYTES-1: index+1, go to ISSUE.
  - Index == SCREEN_BYTES-1: frame_done<=1, go to IDLE.
- Latency: start to first out_valid is 4 cycles with grant held and no backpressure. Steady state is 1 byte per 4 cycles.
- The block never writes memory and has no mem_write port.
- A draw completed before a byte's ISSUE is reflected in that byte. No frame-level coherence is guaranteed.

Optional Feature:
- Macro SCREEN_READER_CONTINUOUS_EN.
- Defined: after the last byte is accepted, frame_done still pulses, index resets to 0 and state goes directly to ISSUE. Frames repeat without further start pulses. ready stays 0 after the first start until reset.
- Not defined: single-frame behaviour as above.

Decomposition:
- Shared package chip8_pkg holds:
  - SCREEN_START default and SCREEN_W=64, SCREEN_H=32, SCREEN_BYTES_PER_ROW=8.
  - The state encoding typedef (IDLE, ISSUE, CAPTURE, OUTPUT).
  - Memory-port widths (16-bit address, 8-bit data).
- GPU and screen_reader both use these constants.
- No sub-module; the output register set is small enough to stay inline.

Test Plan:
- Memory model filled with byte i at 'h100+i; start pulse, out_ready=1, mem_grant=1 -> 256 bytes out with values 0..255 in order. Byte 'h47 reports row 8, col 7. out_first only on byte 0, out_last only on byte 255. frame_done one cycle after the last handshake. First out_valid 4 cycles after start.
- Backpressure: out_ready low for 10 cycles on byte 3 -> out_byte=3, row 0, col 3 held stable. No mem_read issued until acceptance.
- Grant starvation: mem_grant=0 for 5 cycles in ISSUE -> no mem_read. Read issues the cycle after the grant returns, with mem_addr='h100+index.
- Reset mid-frame: rst_n low after byte 100 -> all outputs 0 immediately, ready=1, no frame_done. A new start rescans from 'h100.
- start asserted during a frame -> ignored; exactly one frame_done.
- With SCREEN_READER_CONTINUOUS_EN: one start -> two consecutive frames. The second begins at 'h100 right after the first frame_done, and ready stays 0.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared CHIP-8 video constants: framebuffer geometry, memory-port widths, scan FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package chip8_pkg;

    // Framebuffer geometry: 64 x 32 monochrome, one bit per pixel, MSB is leftmost.
    localparam logic [15:0] SCREEN_START_DEFAULT = 16'h0100;
    localparam int          SCREEN_W             = 64;
    localparam int          SCREEN_H             = 32;
    localparam int          SCREEN_BYTES_PER_ROW = 8;

    // Shared byte-wide memory port.
    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 8;

    // Tag widths for a streamed framebuffer byte.
    localparam int ROW_W = 5;
    localparam int COL_W = 3;

    // Scan FSM encoding, kept as plain constants so older tools can consume it.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ISSUE   = 2'd1;
    localparam state_t ST_CAPTURE = 2'd2;
    localparam state_t ST_OUTPUT  = 2'd3;

endpackage

// File: rtl/screen_reader.sv
// Scans the CHIP-8 framebuffer over the shared memory port and streams bytes tagged with row/col.
// Latency: first out_valid 4 cycles after start (grant held); steady state one byte per 4 cycles.
// Backpressure: out_* held while out_valid && !out_ready; no new read is issued until acceptance.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start / ready / frame_done frame control: start sampled in IDLE, ready = IDLE, done pulse
//   mem_grant / mem_read / mem_addr / mem_read_byte
//                              read-only memory port; data arrives the cycle after mem_read
//   out_valid / out_ready / out_byte / out_row / out_col / out_first / out_last
//                              byte stream to the display driver
//
// Build option: define SCREEN_READER_CONTINUOUS_EN to rescan frames back to back after one start.
module screen_reader
    import chip8_pkg::*;
#(
    parameter logic [MEM_ADDR_W-1:0] SCREEN_START = SCREEN_START_DEFAULT,
    parameter int                    SCREEN_BYTES = 256   // power of two, 8..256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  ready,
    output logic                  frame_done,
    input  logic                  mem_grant,
    output logic                  mem_read,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [MEM_DATA_W-1:0] mem_read_byte,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MEM_DATA_W-1:0] out_byte,
    output logic [ROW_W-1:0]      out_row,
    output logic [COL_W-1:0]      out_col,
    output logic                  out_first,
    output logic                  out_last
);

    // An 8-bit index covers the largest legal frame; smaller frames leave upper bits zero,
    // so row/col can always be sliced straight out of the index.
    localparam int               IDX_W    = 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SCREEN_BYTES - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;

    assign ready = (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            frame_done <= 1'b0;
            mem_read   <= 1'b0;
            mem_addr   <= '0;
            out_valid  <= 1'b0;
            out_byte   <= '0;
            out_row    <= '0;
            out_col    <= '0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            // Strobes and the address bus are single-cycle; they fall back to zero unless set below.
            mem_read   <= 1'b0;
            mem_addr   <= '0;
            frame_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        state <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (mem_grant) begin
                        mem_read <= 1'b1;
                        mem_addr <= SCREEN_START + MEM_ADDR_W'(idx);
                        state    <= ST_CAPTURE;
                    end
                end

                // First CAPTURE cycle has mem_read still high (strobe cycle); the data is
                // on mem_read_byte in the following cycle, once the strobe has dropped.
                ST_CAPTURE: begin
                    if (!mem_read) begin
                        out_byte  <= mem_read_byte;
                        out_row   <= idx[IDX_W-1:COL_W];
                        out_col   <= idx[COL_W-1:0];
                        out_first <= (idx == '0);
                        out_last  <= (idx == LAST_IDX);
                        out_valid <= 1'b1;
                        state     <= ST_OUTPUT;
                    end
                end

                ST_OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            frame_done <= 1'b1;
`ifdef SCREEN_READER_CONTINUOUS_EN
                            idx   <= '0;
                            state <= ST_ISSUE;
`else
                            state <= ST_IDLE;
`endif
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= ST_ISSUE;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_screen_reader.sv
// Self-checking bench for screen_reader: memory model, address log and per-byte reference.
// Latency: n/a (bench).
// Backpressure: the bench drives out_ready low on chosen/random bytes and checks the hold.
module tb_screen_reader;

    localparam int          SB = 256;
    localparam logic [15:0] SS = 16'h0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        ready;
    logic        frame_done;
    logic        mem_grant;
    logic        mem_read;
    logic [15:0] mem_addr;
    logic [7:0]  mem_read_byte;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic [4:0]  out_row;
    logic [2:0]  out_col;
    logic        out_first;
    logic        out_last;

    int n_cmp = 0;
    int n_err = 0;
    int fd_cnt = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] addr_q[$];

    always #5 clk = ~clk;

    screen_reader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .ready         (ready),
        .frame_done    (frame_done),
        .mem_grant     (mem_grant),
        .mem_read      (mem_read),
        .mem_addr      (mem_addr),
        .mem_read_byte (mem_read_byte),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_byte      (out_byte),
        .out_row       (out_row),
        .out_col       (out_col),
        .out_first     (out_first),
        .out_last      (out_last)
    );

    // Memory returns data in the cycle after the read strobe; every strobe's address is logged.
    always @(posedge clk) begin
        if (mem_read === 1'b1) begin
            mem_read_byte <= mem[mem_addr];
            addr_q.push_back(mem_addr);
        end
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string sfx);
        chk({"ready_", sfx},      32'(ready),      32'd1);
        chk({"out_valid_", sfx},  32'(out_valid),  32'd0);
        chk({"mem_read_", sfx},   32'(mem_read),   32'd0);
        chk({"mem_addr_", sfx},   32'(mem_addr),   32'd0);
        chk({"frame_done_", sfx}, 32'(frame_done), 32'd0);
        chk({"out_byte_", sfx},   32'(out_byte),   32'd0);
        chk({"out_row_", sfx},    32'(out_row),    32'd0);
        chk({"out_col_", sfx},    32'(out_col),    32'd0);
        chk({"out_first_", sfx},  32'(out_first),  32'd0);
        chk({"out_last_", sfx},   32'(out_last),   32'd0);
    endtask

    task automatic fill_identity();
        for (int i = 0; i < SB; i++) mem[SS + 16'(i)] = 8'(i);
    endtask

    task automatic fill_random();
        for (int i = 0; i < SB; i++) mem[SS + 16'(i)] = 8'($urandom_range(0, 255));
    endtask

    // One start pulse; optionally measures cycles from the start cycle to the first out_valid.
    task automatic pulse_start(input bit meas);
        int cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (meas) begin
            chk("ready_after_start", 32'(ready), 32'd0);
            cnt = 1;
            while (out_valid !== 1'b1 && cnt < 50) begin
                @(posedge clk); #1;
                cnt++;
            end
            chk("start_latency", 32'(cnt), 32'd4);
        end
    endtask

    // Consumes one frame against the reference. rnd: random grant gaps, backpressure, stray start.
    // Otherwise: 10-cycle hold on byte 3, 5-cycle grant starvation after byte 10.
    // Returns right after accepting byte abort_at (if >= 0).
    task automatic do_frame(input bit rnd, input int abort_at);
        int          guard;
        int          hold;
        logic [15:0] a;
        logic [7:0]  eb;
        for (int i = 0; i < SB; i++) begin
            guard = 0;
            while (out_valid !== 1'b1 && guard < 100) begin
                if (rnd) mem_grant = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                guard++;
            end
            mem_grant = 1'b1;
            chk("valid_seen", 32'(out_valid), 32'd1);
            if (out_valid !== 1'b1) return;

            a  = SS + 16'(i);
            eb = mem[a];
            chk("byte",  32'(out_byte),  32'(eb));
            chk("row",   32'(out_row),   32'(i / 8));
            chk("col",   32'(out_col),   32'(i % 8));
            chk("first", 32'(out_first), 32'(i == 0));
            chk("last",  32'(out_last),  32'(i == SB - 1));
            if (i == 'h47) begin
                chk("row_0x47", 32'(out_row), 32'd8);
                chk("col_0x47", 32'(out_col), 32'd7);
            end
            chk("reads_per_byte", 32'(addr_q.size()), 32'd1);
            if (addr_q.size() > 0) chk("read_addr", 32'(addr_q.pop_front()), 32'(a));

            hold = rnd ? $urandom_range(0, 3) : ((i == 3) ? 10 : 0);
            if (rnd && i == 50) start = 1'b1;
            if (hold > 0) begin
                out_ready = 1'b0;
                for (int h = 0; h < hold; h++) begin
                    @(posedge clk); #1;
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_byte",  32'(out_byte),  32'(eb));
                    chk("hold_row",   32'(out_row),   32'(i / 8));
                    chk("hold_col",   32'(out_col),   32'(i % 8));
                    chk("hold_noread", 32'(mem_read), 32'd0);
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            chk("valid_dropped", 32'(out_valid), 32'd0);
            if (i == abort_at) return;

            if (i == SB - 1) begin
                chk("frame_done_pulse", 32'(frame_done), 32'd1);
                @(posedge clk); #1;
                chk("frame_done_clear", 32'(frame_done), 32'd0);
            end else begin
                chk("frame_done_early", 32'(frame_done), 32'd0);
            end

            if (!rnd && i == 10) begin
                mem_grant = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk); #1;
                    chk("starve_noread", 32'(mem_read), 32'd0);
                end
                mem_grant = 1'b1;
                @(posedge clk); #1;
                chk("grant_read", 32'(mem_read), 32'd1);
                chk("grant_addr", 32'(mem_addr), 32'(SS + 16'd11));
            end
        end
    endtask

    initial begin
        int fd_before;
        rst_n     = 1'b0;
        start     = 1'b0;
        mem_grant = 1'b1;
        out_ready = 1'b1;
        fill_identity();

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_idle", 32'(ready), 32'd1);

        // Frame 1: identity contents, directed hold and starvation.
        pulse_start(1'b1);
        do_frame(1'b0, -1);

        // Frame 2: random contents, random grant and backpressure, stray start mid-frame.
        fill_random();
        fd_before = fd_cnt;
`ifdef SCREEN_READER_CONTINUOUS_EN
        chk("ready_continuous", 32'(ready), 32'd0);
`else
        chk("ready_after_frame", 32'(ready), 32'd1);
        pulse_start(1'b0);
`endif
        do_frame(1'b1, -1);
        repeat (2) @(posedge clk);
        #1;
        chk("one_frame_done", 32'(fd_cnt - fd_before), 32'd1);
`ifdef SCREEN_READER_CONTINUOUS_EN
        chk("ready_still_low", 32'(ready), 32'd0);
`endif

        // Frame 3: abandoned by reset after byte 100.
        fill_random();
        pulse_start(1'b0);
        do_frame(1'b0, 100);
        fd_before = fd_cnt;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        addr_q.delete();
        @(posedge clk); #1;
        chk("no_done_on_abort", 32'(fd_cnt - fd_before), 32'd0);
        chk("ready_after_abort", 32'(ready), 32'd1);

        // Frame 4: fresh scan from the base address after the abort.
        fill_random();
        pulse_start(1'b1);
        do_frame(1'b1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
